fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the 8-bit CPU. Owns the program counter, drives the 8-bit `pc` into the combinational instruction memory, and registers the returned 16-bit word into an instruction register for the decode/execute stage. Handles stalls, redirects from execute (taken JMP/JZ), a HALT state, and optional early resolution of unconditional JMP.

## Interface
Parameters:
- `RESET_PC`, 8'h00: PC value loaded on reset.
- `HALT_WORD`, 16'hFFFF: instruction encoding that halts fetch.

Ports:
- `clk`  input  1  system clock; all state updates on rising edge.
- `rst_n`  input  1  reset, synchronous, active-low.
- `pc`  output  8  address to instruction memory.
- `instruction`  input  16  word returned by instruction memory for `pc`, same cycle.
- `stall`  input  1  downstream not ready; hold fetch state.
- `redirect_valid`  input  1  execute resolved a taken branch.
- `redirect_target`  input  8  new PC when `redirect_valid`=1.
- `ir`  output  16  registered instruction for decode.
- `ir_pc`  output  8  address `ir` was fetched from.
- `ir_valid`  output  1  `ir` holds a real instruction (0 = bubble).
- `halted`  output  1  fetch is in HALTED state.
- `ir_early_jmp`  output  1  `ir` is a JMP already resolved by fetch (0 unless `FETCH_EARLY_JMP_EN`).

## Operation
- States: RUN, HALTED.
- Reset (`rst_n`=0 at edge): state=RUN, `pc`=RESET_PC, `ir`=16'h0000, `ir_pc`=8'h00, `ir_valid`=0, `halted`=0, `ir_early_jmp`=0. Reset overrides every other input.
- Per-edge priority in RUN: reset > redirect > stall > HALT detect > early JMP > normal.
- Redirect (`redirect_valid`=1): `pc`<=`redirect_target`; `ir_valid`<=0 (squashes the word fetched this cycle); `ir`, `ir_pc` don't-care but held. Applies even if `stall`=1.
- Stall (`stall`=1, no redirect): `pc`, `ir`, `ir_pc`, `ir_valid`, `ir_early_jmp` all hold.
- HALT detect (`instruction`==HALT_WORD): `ir`<=HALT_WORD, `ir_pc`<=`pc`, `ir_valid`<=1, `pc` holds, state<=HALTED.
- Normal: `ir`<=`instruction`, `ir_pc`<=`pc`, `ir_valid`<=1, `pc`<=`pc`+1 modulo 256 (8'hFF wraps to 8'h00).
- HALTED: `halted`=1; `pc` frozen; `ir_valid`<=0 from the following edge (HALT word delivered exactly once). `stall` has no effect. Leave only by reset or `redirect_valid`=1 (`pc`<=target, `ir_valid`<=0, state<=RUN).
- Opcode field is `instruction[15:12]`; branch target field is `instruction[11:4]` (JMP 8'h8, JZ 8'h9).

## Timing
- `pc` is a register; instruction memory is combinational, so the word for `pc` is captured into `ir` at the same edge `pc` advances: fetch latency 1 cycle.
- Taken branch via redirect: 1 bubble (`ir_valid`=0 for one cycle), target word in `ir` one cycle after the redirect edge.
- Back-to-back redirects: each wins; the last one sets `pc`.
- Stall released: fetch resumes at the held `pc` with no lost or duplicated instruction.
- Reset asserted mid-stall, mid-redirect, or in HALTED: next edge yields reset values.

## Configuration
- `FETCH_EARLY_JMP_EN` defined: in RUN, no redirect/stall, `instruction[15:12]`==4'h8 → `ir`<=`instruction`, `ir_valid`<=1, `ir_early_jmp`<=1, `pc`<=`instruction[11:4]`. Zero-bubble JMP; execute must not raise `redirect_valid` for an `ir` with `ir_early_jmp`=1. JZ always resolved by execute.
- Not defined: JMP treated as normal (`pc`+1), `ir_early_jmp` tied 0; execute redirects, 1 bubble.

## Test plan
- Reset then run with program 16'hC005,16'hC107,16'h0010: `ir` sequence C005@pc0, C107@pc1, 0010@pc2, `ir_valid`=1 from first edge after reset release.
- Stall for 3 cycles at pc=2 → `ir`,`ir_pc`,`pc` hold; after release `ir`=0010 not repeated, next `ir_pc`=3.
- Redirect at pc=6 with target 8'h03 (concurrent `stall`=1) → one cycle `ir_valid`=0, then `ir_pc`=3.
- PC at 8'hFF, normal fetch → `pc`=8'h00 next cycle.
- `instruction`=16'hFFFF at pc=7 → `ir`=FFFF valid once, `halted`=1, `pc` stays 7; redirect to 8'h00 → `halted`=0, fetch resumes at 0.
- With `FETCH_EARLY_JMP_EN`, 16'h8020 at pc=5 → `ir_early_jmp`=1, next `ir_pc`=2 with no bubble; without macro → next `ir_pc`=6 until redirect.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, instruction register, stall/redirect/halt handling
// Optional FETCH_EARLY_JMP_EN resolves unconditional JMP in fetch with zero bubbles.
module fetch_unit #(
  parameter logic [7:0]  RESET_PC  = 8'h00,
  parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [7:0]  pc,
  input  logic [15:0] instruction,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [7:0]  redirect_target,
  output logic [15:0] ir,
  output logic [7:0]  ir_pc,
  output logic        ir_valid,
  output logic        halted,
  output logic        ir_early_jmp
);

  typedef enum logic {
    RUN,
    HALTED
  } state_t;

  state_t state;

`ifdef FETCH_EARLY_JMP_EN
  localparam logic [3:0] OP_JMP = 4'h8;
  logic early_jmp_q;
  assign ir_early_jmp = early_jmp_q;
`else
  assign ir_early_jmp = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= RUN;
      pc       <= RESET_PC;
      ir       <= 16'h0000;
      ir_pc    <= 8'h00;
      ir_valid <= 1'b0;
      halted   <= 1'b0;
`ifdef FETCH_EARLY_JMP_EN
      early_jmp_q <= 1'b0;
`endif
    end else begin
      case (state)
        RUN: begin
          if (redirect_valid) begin
            // Word fetched this cycle is on the wrong path; drop it.
            pc       <= redirect_target;
            ir_valid <= 1'b0;
`ifdef FETCH_EARLY_JMP_EN
            early_jmp_q <= 1'b0;
`endif
          end else if (stall) begin
            pc <= pc;
          end else if (instruction == HALT_WORD) begin
            ir       <= instruction;
            ir_pc    <= pc;
            ir_valid <= 1'b1;
            state    <= HALTED;
            halted   <= 1'b1;
`ifdef FETCH_EARLY_JMP_EN
            early_jmp_q <= 1'b0;
`endif
          end
`ifdef FETCH_EARLY_JMP_EN
          else if (instruction[15:12] == OP_JMP) begin
            ir          <= instruction;
            ir_pc       <= pc;
            ir_valid    <= 1'b1;
            early_jmp_q <= 1'b1;
            pc          <= instruction[11:4];
          end
`endif
          else begin
            ir       <= instruction;
            ir_pc    <= pc;
            ir_valid <= 1'b1;
            pc       <= pc + 8'd1;
`ifdef FETCH_EARLY_JMP_EN
            early_jmp_q <= 1'b0;
`endif
          end
        end
        HALTED: begin
          // HALT word was delivered on entry; only a redirect (or reset) restarts fetch.
          ir_valid <= 1'b0;
`ifdef FETCH_EARLY_JMP_EN
          early_jmp_q <= 1'b0;
`endif
          if (redirect_valid) begin
            pc     <= redirect_target;
            state  <= RUN;
            halted <= 1'b0;
          end
        end
        default: begin
          state  <= RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with a fetch scoreboard
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  pc;
  logic [15:0] instruction;
  logic        stall;
  logic        redirect_valid;
  logic [7:0]  redirect_target;
  logic [15:0] ir;
  logic [7:0]  ir_pc;
  logic        ir_valid;
  logic        halted;
  logic        ir_early_jmp;

  logic [15:0] imem [256];
  logic [23:0] sb [$];
  int checks = 0;
  int failures = 0;

  assign instruction = imem[pc];

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .instruction(instruction),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .halted(halted), .ir_early_jmp(ir_early_jmp)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired, got no finish, required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 8'h00;
    tick(); tick();
    checks++; if (pc !== 8'h00) begin failures++; $display("FAIL reset_pc: got %h want 00", pc); end
    checks++; if (ir !== 16'h0000) begin failures++; $display("FAIL reset_ir: got %h want 0000", ir); end
    checks++; if (ir_pc !== 8'h00) begin failures++; $display("FAIL reset_ir_pc: got %h want 00", ir_pc); end
    checks++; if (ir_valid !== 1'b0) begin failures++; $display("FAIL reset_ir_valid: got %b want 0", ir_valid); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted: got %b want 0", halted); end
    checks++; if (ir_early_jmp !== 1'b0) begin failures++; $display("FAIL reset_early: got %b want 0", ir_early_jmp); end
  endtask

  task automatic test_run();
    logic [23:0] e;
    rst_n = 1'b1;
    sb.push_back({8'h00, 16'hC005});
    sb.push_back({8'h01, 16'hC107});
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (ir_valid !== 1'b1) begin failures++; $display("FAIL run_valid: cycle %0d got %b want 1", i, ir_valid); end
      else if (sb.size() == 0) begin failures++; $display("FAIL run_sb: got unexpected %h@%h want none", ir, ir_pc); end
      else begin
        e = sb.pop_front();
        if ({ir_pc, ir} !== e) begin failures++; $display("FAIL run_word: got %h@%h want %h@%h", ir, ir_pc, e[15:0], e[23:16]); end
      end
    end
    checks++; if (pc !== 8'h02) begin failures++; $display("FAIL run_pc: got %h want 02", pc); end
  endtask

  task automatic test_stall();
    logic [23:0] e;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({pc, ir_pc, ir, ir_valid} !== {8'h02, 8'h01, 16'hC107, 1'b1}) begin
        failures++;
        $display("FAIL stall_hold: cycle %0d got pc=%h ir=%h@%h v=%b want pc=02 ir=c107@01 v=1", i, pc, ir, ir_pc, ir_valid);
      end
    end
    stall = 1'b0;
    for (int a = 2; a < 6; a++) sb.push_back({a[7:0], 16'h1000 | 16'(a)});
    sb[0] = {8'h02, 16'h0010};
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (ir_valid !== 1'b1) begin failures++; $display("FAIL resume_valid: cycle %0d got %b want 1", i, ir_valid); end
      else if (sb.size() == 0) begin failures++; $display("FAIL resume_sb: got unexpected %h@%h want none", ir, ir_pc); end
      else begin
        e = sb.pop_front();
        if ({ir_pc, ir} !== e) begin failures++; $display("FAIL resume_word: got %h@%h want %h@%h", ir, ir_pc, e[15:0], e[23:16]); end
      end
    end
  endtask

  task automatic test_redirect();
    logic [23:0] e;
    checks++; if (pc !== 8'h06) begin failures++; $display("FAIL redir_pre_pc: got %h want 06", pc); end
    redirect_valid = 1'b1; redirect_target = 8'h03; stall = 1'b1;
    tick();
    redirect_valid = 1'b0; stall = 1'b0;
    checks++; if (ir_valid !== 1'b0) begin failures++; $display("FAIL redir_bubble: got %b want 0", ir_valid); end
    checks++; if (pc !== 8'h03) begin failures++; $display("FAIL redir_pc: got %h want 03", pc); end
    sb.push_back({8'h03, 16'h1003});
    tick();
    checks++;
    if (ir_valid !== 1'b1 || sb.size() == 0) begin failures++; $display("FAIL redir_valid: got %b want 1", ir_valid); end
    else begin
      e = sb.pop_front();
      if ({ir_pc, ir} !== e) begin failures++; $display("FAIL redir_word: got %h@%h want %h@%h", ir, ir_pc, e[15:0], e[23:16]); end
    end
  endtask

  task automatic test_wrap();
    logic [23:0] e;
    redirect_valid = 1'b1; redirect_target = 8'hFF;
    tick();
    redirect_valid = 1'b0;
    checks++; if (pc !== 8'hFF) begin failures++; $display("FAIL wrap_pre_pc: got %h want ff", pc); end
    sb.push_back({8'hFF, 16'h10FF});
    tick();
    checks++; if (pc !== 8'h00) begin failures++; $display("FAIL wrap_pc: got %h want 00", pc); end
    checks++;
    if (ir_valid !== 1'b1 || sb.size() == 0) begin failures++; $display("FAIL wrap_valid: got %b want 1", ir_valid); end
    else begin
      e = sb.pop_front();
      if ({ir_pc, ir} !== e) begin failures++; $display("FAIL wrap_word: got %h@%h want %h@%h", ir, ir_pc, e[15:0], e[23:16]); end
    end
  endtask

  task automatic test_halt();
    logic [23:0] e;
    imem[7] = 16'hFFFF;
    redirect_valid = 1'b1; redirect_target = 8'h07;
    tick();
    redirect_valid = 1'b0;
    sb.push_back({8'h07, 16'hFFFF});
    tick();
    checks++;
    if (ir_valid !== 1'b1 || sb.size() == 0) begin failures++; $display("FAIL halt_valid: got %b want 1", ir_valid); end
    else begin
      e = sb.pop_front();
      if ({ir_pc, ir} !== e) begin failures++; $display("FAIL halt_word: got %h@%h want %h@%h", ir, ir_pc, e[15:0], e[23:16]); end
    end
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_flag: got %b want 1", halted); end
    for (int i = 0; i < 3; i++) begin
      stall = (i == 1);
      tick();
      checks++;
      if ({pc, ir_valid, halted} !== {8'h07, 1'b0, 1'b1}) begin
        failures++;
        $display("FAIL halt_hold: cycle %0d got pc=%h v=%b h=%b want pc=07 v=0 h=1", i, pc, ir_valid, halted);
      end
    end
    stall = 1'b0;
    redirect_valid = 1'b1; redirect_target = 8'h00;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if ({pc, ir_valid, halted} !== {8'h00, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL halt_exit: got pc=%h v=%b h=%b want pc=00 v=0 h=0", pc, ir_valid, halted);
    end
    sb.push_back({8'h00, 16'hC005});
    tick();
    checks++;
    if (ir_valid !== 1'b1 || sb.size() == 0) begin failures++; $display("FAIL halt_resume_valid: got %b want 1", ir_valid); end
    else begin
      e = sb.pop_front();
      if ({ir_pc, ir} !== e) begin failures++; $display("FAIL halt_resume_word: got %h@%h want %h@%h", ir, ir_pc, e[15:0], e[23:16]); end
    end
    imem[7] = 16'h1007;
  endtask

  task automatic test_early_jmp();
    logic [23:0] e;
    logic [7:0]  next_pc;
    logic        exp_early;
`ifdef FETCH_EARLY_JMP_EN
    next_pc = 8'h02; exp_early = 1'b1;
`else
    next_pc = 8'h06; exp_early = 1'b0;
`endif
    imem[5] = 16'h8020;
    redirect_valid = 1'b1; redirect_target = 8'h05;
    tick();
    redirect_valid = 1'b0;
    sb.push_back({8'h05, 16'h8020});
    tick();
    checks++;
    if (ir_valid !== 1'b1 || sb.size() == 0) begin failures++; $display("FAIL jmp_valid: got %b want 1", ir_valid); end
    else begin
      e = sb.pop_front();
      if ({ir_pc, ir} !== e) begin failures++; $display("FAIL jmp_word: got %h@%h want %h@%h", ir, ir_pc, e[15:0], e[23:16]); end
    end
    checks++; if (ir_early_jmp !== exp_early) begin failures++; $display("FAIL jmp_early: got %b want %b", ir_early_jmp, exp_early); end
    checks++; if (pc !== next_pc) begin failures++; $display("FAIL jmp_pc: got %h want %h", pc, next_pc); end
    sb.push_back({next_pc, 16'h1000 | {8'h00, next_pc}});
    if (next_pc == 8'h02) sb[sb.size()-1] = {8'h02, 16'h0010};
    tick();
    checks++;
    if (ir_valid !== 1'b1 || sb.size() == 0) begin failures++; $display("FAIL jmp_next_valid: got %b want 1", ir_valid); end
    else begin
      e = sb.pop_front();
      if ({ir_pc, ir} !== e) begin failures++; $display("FAIL jmp_next_word: got %h@%h want %h@%h", ir, ir_pc, e[15:0], e[23:16]); end
    end
    checks++; if (ir_early_jmp !== 1'b0) begin failures++; $display("FAIL jmp_early_clear: got %b want 0", ir_early_jmp); end
    imem[5] = 16'h1005;
  endtask

  task automatic test_back_to_back();
    logic [23:0] e;
    redirect_valid = 1'b1; redirect_target = 8'h10;
    tick();
    redirect_target = 8'h20;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if ({pc, ir_valid} !== {8'h20, 1'b0}) begin failures++; $display("FAIL b2b_pc: got pc=%h v=%b want pc=20 v=0", pc, ir_valid); end
    sb.push_back({8'h20, 16'h1020});
    tick();
    checks++;
    if (ir_valid !== 1'b1 || sb.size() == 0) begin failures++; $display("FAIL b2b_valid: got %b want 1", ir_valid); end
    else begin
      e = sb.pop_front();
      if ({ir_pc, ir} !== e) begin failures++; $display("FAIL b2b_word: got %h@%h want %h@%h", ir, ir_pc, e[15:0], e[23:16]); end
    end
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0; stall = 1'b1; redirect_valid = 1'b1; redirect_target = 8'h44;
    tick();
    checks++;
    if ({pc, ir, ir_pc, ir_valid, halted} !== {8'h00, 16'h0000, 8'h00, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid: got pc=%h ir=%h@%h v=%b h=%b want all zero", pc, ir, ir_pc, ir_valid, halted);
    end
    stall = 1'b0; redirect_valid = 1'b0; rst_n = 1'b1;
    imem[0] = 16'hFFFF;
    tick();
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL reset_halt_pre: got %b want 1", halted); end
    rst_n = 1'b0;
    tick();
    checks++;
    if ({pc, ir, ir_valid, halted} !== {8'h00, 16'h0000, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_halted: got pc=%h ir=%h v=%b h=%b want pc=00 ir=0000 v=0 h=0", pc, ir, ir_valid, halted);
    end
    imem[0] = 16'hC005;
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 16'h1000 | 16'(i);
    imem[0] = 16'hC005;
    imem[1] = 16'hC107;
    imem[2] = 16'h0010;
    test_reset();
    test_run();
    test_stall();
    test_redirect();
    test_wrap();
    test_halt();
    test_early_jmp();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL sb_drain: got %0d left want 0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
